// File: rtl/branch_predict_unit.sv
// EX-stage RV32I branch resolution with a 2-bit saturating BHT for IF prediction,
// misprediction/redirect generation and saturating performance counters.
module branch_predict_unit #(
  parameter int         WIDTH     = 32,
  parameter int         BHT_IDX_W = 4,
  parameter int         CNT_W     = 32,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_func3,
  input  logic             ex_zero,
  input  logic             ex_less_signed,
  input  logic             ex_less_unsigned,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [ENTRIES];
  logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]     mis_cnt_q, mis_cnt_d;
  logic                 dir_taken, legal, res;
  logic [BHT_IDX_W-1:0] if_idx, ex_idx;
  logic [WIDTH-1:0]     pc_plus4;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  assign if_idx = if_pc[BHT_IDX_W+1:2];
  assign ex_idx = ex_pc[BHT_IDX_W+1:2];

  always_comb begin
    dir_taken = 1'b0;
    legal     = 1'b1;
    case (ex_func3)
      3'b000:  dir_taken = ex_zero;
      3'b001:  dir_taken = !ex_zero;
      3'b100:  dir_taken = ex_less_signed;
      3'b101:  dir_taken = !ex_less_signed;
      3'b110:  dir_taken = ex_less_unsigned;
      3'b111:  dir_taken = !ex_less_unsigned;
      default: legal     = 1'b0;
    endcase
  end

  assign res         = ex_valid & ex_branch & legal;
  assign ex_taken    = res & dir_taken;
  assign mispredict  = res & (dir_taken != ex_pred_taken);
  assign pc_plus4    = ex_pc + WIDTH'(4);
  // ex_taken already folds in res, so the idle case naturally falls back to pc+4.
  assign redirect_pc = ex_taken ? ex_target : pc_plus4;

  // Lookup reads the stored value, so a same-cycle update is seen only next cycle.
  assign if_pred_taken = bht_q[if_idx][1];

  assign branch_cnt_d = sat_inc(branch_cnt_q, res);
  assign mis_cnt_d    = sat_inc(mis_cnt_q, mispredict);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= BHT_INIT;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      if (res) bht_q[ex_idx] <= sat_step(bht_q[ex_idx], dir_taken);
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_predict_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_branch;
  logic [2:0]  ex_func3;
  logic        ex_zero, ex_less_signed, ex_less_unsigned;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_predict_unit #(.WIDTH(32), .BHT_IDX_W(4), .CNT_W(CNT_W), .BHT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_func3(ex_func3),
    .ex_zero(ex_zero), .ex_less_signed(ex_less_signed), .ex_less_unsigned(ex_less_unsigned),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       pred;
    bit       taken;
    bit       mis;
    bit [31:0] redir;
    int       bc;
    int       mc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: plain integer counters, one per BHT entry.
  int m_bht[16];
  int m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic drive(input bit v, input bit b, input bit [2:0] f3, input bit z,
                       input bit ls, input bit lu, input bit [31:0] pc,
                       input bit [31:0] tgt, input bit pr, input bit [31:0] ipc);
    exp_t e;
    bit legal, t, res;
    @(posedge clk); #1;
    ex_valid = v; ex_branch = b; ex_func3 = f3; ex_zero = z;
    ex_less_signed = ls; ex_less_unsigned = lu; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pr; if_pc = ipc;
    legal = 1'b1;
    case (f3)
      3'd0: t = z;
      3'd1: t = !z;
      3'd4: t = ls;
      3'd5: t = !ls;
      3'd6: t = lu;
      3'd7: t = !lu;
      default: begin t = 1'b0; legal = 1'b0; end
    endcase
    res     = v && b && legal;
    e.pred  = m_bht[ipc[5:2]] >= 2;
    e.taken = res && t;
    e.mis   = res && (t != pr);
    e.redir = (res && t) ? tgt : pc + 32'd4;
    e.bc    = m_bc;
    e.mc    = m_mc;
    q.push_back(e);
    if (res) begin
      m_bht[pc[5:2]] = t ? ((m_bht[pc[5:2]] < 3) ? m_bht[pc[5:2]] + 1 : 3)
                         : ((m_bht[pc[5:2]] > 0) ? m_bht[pc[5:2]] - 1 : 0);
      if (m_bc < CMAX) m_bc++;
      if (e.mis && m_mc < CMAX) m_mc++;
    end
  endtask

  task automatic idle(input bit [31:0] ipc);
    drive(0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 0, ipc);
  endtask

  // Monitor: compares every expectation the driver queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("if_pred_taken", 32'(if_pred_taken), 32'(e.pred));
        chk("ex_taken", 32'(ex_taken), 32'(e.taken));
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        chk("redirect_pc", redirect_pc, e.redir);
        chk("branch_count", 32'(branch_count), 32'(e.bc));
        chk("mispredict_count", 32'(mispredict_count), 32'(e.mc));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_branch = 0; ex_func3 = 0; ex_zero = 0;
    ex_less_signed = 0; ex_less_unsigned = 0; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; if_pc = 32'h100;
    model_reset();
    #12;
    chk("reset_pred", 32'(if_pred_taken), 32'd0);
    chk("reset_bc", 32'(branch_count), 32'd0);
    chk("reset_mc", 32'(mispredict_count), 32'd0);
    chk("reset_taken", 32'(ex_taken), 32'd0);
    chk("reset_mis", 32'(mispredict), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    idle(32'h100);
    // bge with equal operands: taken, predicted not-taken
    drive(1, 1, 3'd5, 1, 0, 0, 32'h40, 32'h80, 0, 32'h40);
    idle(32'h40);
    // Four taken beq at index 8, then two not-taken
    for (int i = 0; i < 4; i++) drive(1, 1, 3'd0, 1, 0, 0, 32'h20, 32'h200, 0, 32'h20);
    idle(32'h20);
    for (int i = 0; i < 2; i++) drive(1, 1, 3'd0, 0, 0, 0, 32'h20, 32'h200, 1, 32'h20);
    idle(32'h20);
    // Same-cycle lookup and taken update of index 8 while it holds 01
    drive(1, 1, 3'd0, 1, 0, 0, 32'h20, 32'h200, 0, 32'h20);
    idle(32'h20);
    // Illegal func3, then a stalled taken bne
    drive(1, 1, 3'd2, 1, 1, 1, 32'h60, 32'h90, 0, 32'h60);
    drive(1, 1, 3'd3, 0, 0, 0, 32'h60, 32'h90, 1, 32'h60);
    drive(0, 1, 3'd1, 0, 0, 0, 32'h60, 32'h90, 0, 32'h60);
    idle(32'h60);
    // Counter saturation: 20 mispredicted branches
    for (int i = 0; i < 20; i++)
      drive(1, 1, 3'd0, 1, 0, 0, 32'(i * 4), 32'h1000, 0, 32'(i * 4));
    idle(32'h0);
    // Redirect wrap at top of address space
    drive(1, 1, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 32'h1234, 1, 32'hFFFF_FFFC);
    idle(32'h0);

    // Reset mid-operation with a pending update; it must be discarded.
    @(posedge clk); #1;
    ex_valid = 1; ex_branch = 1; ex_func3 = 3'd0; ex_zero = 1; ex_pc = 32'h20;
    ex_pred_taken = 0; if_pc = 32'h20;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    ex_valid = 0; ex_branch = 0;
    rst_n = 1'b1;
    model_reset();
    idle(32'h20);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            {$urandom_range(0, 3) == 0 ? 28'hFFFFFFF : 28'($urandom_range(0, 15)), 4'b0} |
              {28'b0, 2'($urandom), 2'b00},
            $urandom, 1'($urandom), {26'($urandom), 2'($urandom), 2'b00});
    end
    idle(32'h0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
